fp_divider_seq: RTL

- Sequential IEEE-754 single-precision divider, dataR = dataA / dataB; inverse operation of the team's combinational float multiplier.
- Shares the multiplier's field split and special-value encodings.
- Iterative restoring mantissa division, one quotient bit per clock; start/done handshake toward the arithmetic datapath controller.

---
 rtl/fp_pkg.sv | 33 +++
 rtl/fp_divider_seq_if.sv | 22 ++
 rtl/fp_mant_div_seq.sv | 49 ++++
 rtl/fp_divider_seq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared float32 field split, special-value encodings and operand classifier.
// The combinational multiplier and the sequential divider both import this.
package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int QBITS    = 25;

  localparam logic [31:0] QNAN    = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  localparam logic [31:0] NEG_INF = 32'hFF800000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    logic is_zero;
    logic is_inf;
    logic is_nan;
  } fp_class_t;

  // A zero exponent counts as zero whatever the fraction, so denormals flush.
  function automatic fp_class_t classify(input fp32_t x);
    fp_class_t c;
    c.is_zero = (x.exp == 8'h00);
    c.is_inf  = (x.exp == 8'hFF) && (x.frac == 23'd0);
    c.is_nan  = (x.exp == 8'hFF) && (x.frac != 23'd0);
    return c;
  endfunction

endpackage

// File: rtl/fp_divider_seq_if.sv
// Start/done handshake and operand/result bus between the datapath
// controller (master) and the sequential float divider (slave).
interface fp_divider_seq_if;

  logic        start;
  logic [31:0] dataA;
  logic [31:0] dataB;
  logic        busy;
  logic        done;
  logic [31:0] dataR;

  modport master (
    output start, dataA, dataB,
    input  busy, done, dataR
  );

  modport slave (
    input  start, dataA, dataB,
    output busy, done, dataR
  );

endinterface

// File: rtl/fp_mant_div_seq.sv
// Restoring significand divider: one quotient bit per step, MSB first.
// Quotient is floor(mant_a * 2^24 / mant_b), QBITS wide.
module fp_mant_div_seq
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [23:0]      mant_a,
  input  logic [23:0]      mant_b,
  output logic [QBITS-1:0] quot,
  output logic             last
);

  logic [QBITS-1:0] rem;
  logic [QBITS-1:0] diff;
  logic [23:0]      divisor;
  logic [4:0]       count;
  logic             qbit;

  always_comb begin
    qbit = (rem >= {1'b0, divisor});
    diff = qbit ? (rem - {1'b0, divisor}) : rem;
  end

  assign last = (count == 5'd0);

  // After a subtract the remainder is below the divisor, so the shift never
  // loses a set bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem     <= '0;
      divisor <= '0;
      count   <= '0;
      quot    <= '0;
    end else if (load) begin
      rem     <= {1'b0, mant_a};
      divisor <= mant_b;
      count   <= 5'(QBITS - 1);
      quot    <= '0;
    end else if (step) begin
      rem  <= diff << 1;
      quot <= {quot[QBITS-2:0], qbit};
      if (!last) count <= count - 5'd1;
    end
  end

endmodule

// File: rtl/fp_divider_seq.sv
// Sequential IEEE-754 single-precision divider, dataR = dataA / dataB.
// Truncating, denormals flushed; specials resolved at accept.
//
// state  | meaning
// IDLE   | waiting for start (blocked during the done cycle)
// DIV    | one quotient bit per clock, 25 clocks
// NORM   | normalise quotient, exponent range check
// DONE   | result staged; dataR/done update on the exit edge
module fp_divider_seq
  import fp_pkg::*;
(
  input logic              clk,
  input logic              reset,
  fp_divider_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state;
  logic             sign_q;
  logic [7:0]       exp_a_q;
  logic [7:0]       exp_b_q;
  logic [31:0]      res_q;
  logic [31:0]      dataR_q;
  logic             done_q;

  fp32_t            op_a;
  fp32_t            op_b;
  fp_class_t        cls_a;
  fp_class_t        cls_b;
  logic             sgn;
  logic             special;
  logic [31:0]      spec_res;
  logic             accept;

  logic [QBITS-1:0] quot;
  logic             mant_last;
  logic             mant_load;
  logic             mant_step;

  logic signed [9:0] e_norm;
  logic [22:0]       frac_norm;
  logic [31:0]       norm_res;

  assign op_a  = bus.dataA;
  assign op_b  = bus.dataB;
  assign cls_a = classify(op_a);
  assign cls_b = classify(op_b);
  assign sgn   = op_a.sign ^ op_b.sign;

  // Precedence order matters: NaN, then indeterminate forms, then inf, then zero.
  always_comb begin
    special  = 1'b1;
    spec_res = QNAN;
    if (cls_a.is_nan || cls_b.is_nan) begin
      spec_res = QNAN;
    end else if ((cls_a.is_zero && cls_b.is_zero) || (cls_a.is_inf && cls_b.is_inf)) begin
      spec_res = QNAN;
    end else if (cls_a.is_inf || cls_b.is_zero) begin
      spec_res = sgn ? NEG_INF : POS_INF;
    end else if (cls_a.is_zero || cls_b.is_inf) begin
      spec_res = {sgn, 31'd0};
    end else begin
      special = 1'b0;
    end
  end

  assign accept    = (state == S_IDLE) && bus.start && !done_q;
  assign mant_load = accept && !special;
  assign mant_step = (state == S_DIV);

  fp_mant_div_seq u_mant (
    .clk    (clk),
    .reset  (reset),
    .load   (mant_load),
    .step   (mant_step),
    .mant_a ({1'b1, op_a.frac}),
    .mant_b ({1'b1, op_b.frac}),
    .quot   (quot),
    .last   (mant_last)
  );

  // Exponent in 10-bit two's complement so both overflow and underflow show.
  always_comb begin
    e_norm = 10'({2'b00, exp_a_q}) - 10'({2'b00, exp_b_q}) + 10'(EXP_BIAS);
    if (quot[QBITS-1]) begin
      frac_norm = quot[23:1];
    end else begin
      frac_norm = quot[22:0];
      e_norm    = e_norm - 10'sd1;
    end
    if (e_norm >= 10'sd255)
      norm_res = {sign_q, 8'hFF, 23'd0};
    else if (e_norm <= 10'sd0)
      norm_res = {sign_q, 31'd0};
    else
      norm_res = {sign_q, e_norm[7:0], frac_norm};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      sign_q  <= 1'b0;
      exp_a_q <= 8'd0;
      exp_b_q <= 8'd0;
      res_q   <= 32'd0;
      dataR_q <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            sign_q  <= sgn;
            exp_a_q <= op_a.exp;
            exp_b_q <= op_b.exp;
            if (special) begin
              res_q <= spec_res;
              state <= S_DONE;
            end else begin
              state <= S_DIV;
            end
          end
        end
        S_DIV: begin
          if (mant_last) state <= S_NORM;
        end
        S_NORM: begin
          res_q <= norm_res;
          state <= S_DONE;
        end
        S_DONE: begin
          dataR_q <= res_q;
          done_q  <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = (state != S_IDLE) || done_q;
  assign bus.done  = done_q;
  assign bus.dataR = dataR_q;

endmodule
